// File: rtl/multicycle_adder_if.sv
// Start/busy/done handshake and operand/result bus for the multi-cycle adder.
// The master issues operations and the slave (the adder) returns results.
interface multicycle_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             overflow;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, overflow
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, overflow
    );
endinterface

// File: rtl/multicycle_adder.sv
// WIDTH-bit unsigned adder that reuses one 4-bit slice, LSB nibble first,
// with the carry registered between slices; start/busy/done handshake.

module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};
endmodule

module multicycle_adder #(
    parameter int WIDTH = 16  // multiple of 4, at least 8
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_adder_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;
    logic             carry_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH-1:0] sum_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;

    logic             last_slice_s;
    logic [3:0]       slice_a_s;
    logic [3:0]       slice_b_s;
    logic             slice_cin_s;
    logic [3:0]       slice_sum_s;
    logic             slice_ovf_s;

    adder_4bit u_slice (
        .a        (slice_a_s),
        .b        (slice_b_s),
        .carry_in (slice_cin_s),
        .sum      (slice_sum_s),
        .overflow (slice_ovf_s)
    );

    // Select the current operand nibbles and the carry feeding this slice
    always_comb begin
        slice_a_s    = a_r[{idx_r, 2'b00} +: 4];
        slice_b_s    = b_r[{idx_r, 2'b00} +: 4];
        last_slice_s = (idx_r == LAST_IDX);
        if (idx_r == {IDXW{1'b0}}) begin
            slice_cin_s = cin_r;
        end else begin
            slice_cin_s = carry_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> RUN for NSLICE passes -> DONE for one cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand capture, slice-by-slice accumulation and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            cin_r      <= 1'b0;
            carry_r    <= 1'b0;
            idx_r      <= {IDXW{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        cin_r   <= bus.carry_in;
                        carry_r <= 1'b0;
                        idx_r   <= {IDXW{1'b0}};
                    end
                end
                ST_RUN: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= slice_sum_s;
                    carry_r <= slice_ovf_s;
                    idx_r   <= idx_r + IDXW'(1);
                    // Only the MSB slice's carry is the unsigned overflow
                    if (last_slice_s) begin
                        overflow_r <= slice_ovf_s;
                    end
                end
                default: begin
                end
            endcase
            busy_r <= (state_next_s == ST_RUN);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.overflow = overflow_r;
endmodule
